// File: rtl/pong_pkg.sv
// Shared match-control types for the pong score keeper and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } match_state_t;

  // Side encoding shared by serve_dir and winner.
  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/score_keeper_rise_detect.sv
// One-bit rising-edge detector: remembers last cycle's input, flags 0->1.
// Latency: rise is combinational from din against the registered history.
// Backpressure: none; history updates every cycle.
// Ports: clk, reset (sync, active-high), din (level in), rise (edge strobe out).
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Match control for pong: scores, serve delay, point and game-over sequencing.
// Latency: score edge or start sampled at edge N takes effect after edge N.
// Backpressure: none; score/start inputs outside their active states are dropped.
// Ports: clk, reset (sync, active-high), tick (frame strobe), start,
//        score_left/score_right (from ball), ball_reset (to ball),
//        score_l/score_r, serve_dir, game_over, winner.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int SERVE_TICKS = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               score_left,
  input  logic               score_right,
  output logic               ball_reset,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  // Counter must hold SERVE_TICKS because it keeps incrementing on the last tick.
  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  match_state_t       state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [SCORE_W-1:0] sl_q, sr_q, nxt_sl, nxt_sr;
  logic               dir_q, nxt_dir;
  logic               over_q, nxt_over;
  logic               win_q, nxt_win;
  logic               ball_reset_q;
  logic               rise_l, rise_r;

  // Edge history runs in every state so a level held through SERVE is not
  // seen as a fresh point once PLAY begins.
  rise_detect u_rise_l (
    .clk   (clk),
    .reset (reset),
    .din   (score_left),
    .rise  (rise_l)
  );

  rise_detect u_rise_r (
    .clk   (clk),
    .reset (reset),
    .din   (score_right),
    .rise  (rise_r)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sl_q         <= '0;
      sr_q         <= '0;
      dir_q        <= SIDE_LEFT;
      over_q       <= 1'b0;
      win_q        <= SIDE_LEFT;
      ball_reset_q <= 1'b1;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      sl_q         <= nxt_sl;
      sr_q         <= nxt_sr;
      dir_q        <= nxt_dir;
      over_q       <= nxt_over;
      win_q        <= nxt_win;
      // Registered so the ball sees a clean level; only PLAY releases it.
      ball_reset_q <= (nxt_state != PLAY);
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_sl    = sl_q;
    nxt_sr    = sr_q;
    nxt_dir   = dir_q;
    nxt_over  = over_q;
    nxt_win   = win_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt_state = SERVE;
          nxt_sl    = '0;
          nxt_sr    = '0;
          nxt_cnt   = '0;
        end
      end
      SERVE: begin
        if (tick) begin
          nxt_cnt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) nxt_state = PLAY;
        end
      end
      PLAY: begin
        if (rise_l && rise_r) begin
          // Simultaneous points cancel: replay the serve, nobody scores.
          nxt_state = SERVE;
          nxt_cnt   = '0;
        end else if (rise_l) begin
          nxt_sl  = sl_q + SCORE_W'(1);
          nxt_dir = SIDE_RIGHT;
          if (nxt_sl == WIN_VAL) begin
            nxt_state = OVER;
            nxt_over  = 1'b1;
            nxt_win   = SIDE_LEFT;
          end else begin
            nxt_state = SERVE;
            nxt_cnt   = '0;
          end
        end else if (rise_r) begin
          nxt_sr  = sr_q + SCORE_W'(1);
          nxt_dir = SIDE_LEFT;
          if (nxt_sr == WIN_VAL) begin
            nxt_state = OVER;
            nxt_over  = 1'b1;
            nxt_win   = SIDE_RIGHT;
          end else begin
            nxt_state = SERVE;
            nxt_cnt   = '0;
          end
        end
      end
      OVER: begin
        if (start) begin
          nxt_state = SERVE;
          nxt_sl    = '0;
          nxt_sr    = '0;
          nxt_over  = 1'b0;
          nxt_win   = SIDE_LEFT;
          nxt_cnt   = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs straight from registers.
  always_comb begin
    ball_reset = ball_reset_q;
    score_l    = sl_q;
    score_r    = sr_q;
    serve_dir  = dir_q;
    game_over  = over_q;
    winner     = win_q;
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: serve timing, point edge detection,
// simultaneous points, match win/restart, reset mid-serve and mid-rally.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       score_left;
  logic       score_right;
  logic       ball_reset;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  score_keeper #(
    .WIN_SCORE   (7),
    .SCORE_W     (4),
    .SERVE_TICKS (60)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .score_left  (score_left),
    .score_right (score_right),
    .ball_reset  (ball_reset),
    .score_l     (score_l),
    .score_r     (score_r),
    .serve_dir   (serve_dir),
    .game_over   (game_over),
    .winner      (winner)
  );

  // Advance one clock; outputs are then stable for checking.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 60 single-cycle ticks; ball held until the edge sampling the 60th.
  task automatic serve_wait(input string tag);
    for (int i = 0; i < 60; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      chk(tag, 32'(ball_reset), (i == 59) ? 32'd0 : 32'd1);
      cycle();
    end
  endtask

  // Ticks that must not release the ball (IDLE after reset).
  task automatic idle_ticks(input string tag);
    for (int i = 0; i < 70; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
    end
    chk(tag, 32'(ball_reset), 32'd1);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0;
    score_left = 1'b0; score_right = 1'b0;
    cycle();
    cycle();
    chk("rst_ball_reset", 32'(ball_reset), 32'd1);
    chk("rst_score_l",    32'(score_l),    32'd0);
    chk("rst_score_r",    32'(score_r),    32'd0);
    chk("rst_serve_dir",  32'(serve_dir),  32'd0);
    chk("rst_game_over",  32'(game_over),  32'd0);
    chk("rst_winner",     32'(winner),     32'd0);
    reset = 1'b0;
    cycle();
    chk("idle_ball_reset", 32'(ball_reset), 32'd1);

    // Start with a coincident tick: that tick must not count.
    start = 1'b1; tick = 1'b1;
    cycle();
    start = 1'b0; tick = 1'b0;
    chk("start_ball_reset", 32'(ball_reset), 32'd1);
    serve_wait("serve1");

    // Left held 5 cycles: exactly one point.
    score_left = 1'b1;
    cycle();
    chk("hold_l_score",     32'(score_l),    32'd1);
    chk("hold_l_dir",       32'(serve_dir),  32'd1);
    chk("hold_l_ballreset", 32'(ball_reset), 32'd1);
    repeat (4) cycle();
    chk("hold_l_once",      32'(score_l),    32'd1);
    score_left = 1'b0;
    cycle();
    serve_wait("serve2");

    // Both rise together: no point, back to SERVE.
    score_left = 1'b1; score_right = 1'b1;
    cycle();
    chk("both_score_l",   32'(score_l),    32'd1);
    chk("both_score_r",   32'(score_r),    32'd0);
    chk("both_dir",       32'(serve_dir),  32'd1);
    chk("both_ballreset", 32'(ball_reset), 32'd1);
    score_left = 1'b0; score_right = 1'b0;
    cycle();
    serve_wait("serve_both");

    // Left runs out the match.
    for (int p = 2; p <= 7; p++) begin
      score_left = 1'b1;
      cycle();
      chk("lwin_score_l", 32'(score_l), 32'(p));
      chk("lwin_over",    32'(game_over), (p == 7) ? 32'd1 : 32'd0);
      score_left = 1'b0;
      cycle();
      if (p < 7) serve_wait("lwin_serve");
    end
    chk("lwin_winner",    32'(winner),     32'd0);
    chk("lwin_ballreset", 32'(ball_reset), 32'd1);

    // Scores frozen in OVER.
    score_right = 1'b1; tick = 1'b1;
    cycle();
    score_right = 1'b0; score_left = 1'b1;
    cycle();
    score_left = 1'b0; tick = 1'b0;
    cycle();
    chk("frozen_score_l", 32'(score_l),   32'd7);
    chk("frozen_score_r", 32'(score_r),   32'd0);
    chk("frozen_over",    32'(game_over), 32'd1);

    // Restart from OVER.
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_score_l",   32'(score_l),    32'd0);
    chk("restart_over",      32'(game_over),  32'd0);
    chk("restart_winner",    32'(winner),     32'd0);
    chk("restart_ballreset", 32'(ball_reset), 32'd1);

    // Reset at tick 30 of a serve.
    for (int i = 0; i < 30; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
    end
    chk("mid_serve_held", 32'(ball_reset), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_serve_ballreset", 32'(ball_reset), 32'd1);
    chk("rst_serve_score_l",   32'(score_l),    32'd0);
    chk("rst_serve_dir",       32'(serve_dir),  32'd0);
    idle_ticks("rst_serve_idle");

    // Right scores 3, then reset mid-rally.
    start = 1'b1;
    cycle();
    start = 1'b0;
    serve_wait("serve_r");
    for (int p = 1; p <= 3; p++) begin
      score_right = 1'b1;
      cycle();
      chk("r_score_r", 32'(score_r),   32'(p));
      chk("r_dir",     32'(serve_dir), 32'd0);
      score_right = 1'b0;
      cycle();
      serve_wait("r_serve");
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_play_score_r",   32'(score_r),    32'd0);
    chk("rst_play_ballreset", 32'(ball_reset), 32'd1);
    chk("rst_play_over",      32'(game_over),  32'd0);
    idle_ticks("rst_play_idle");

    // Right held high across SERVE into PLAY: no point until re-armed.
    start = 1'b1;
    cycle();
    start = 1'b0;
    score_right = 1'b1;
    serve_wait("serve_held");
    repeat (3) cycle();
    chk("held_no_point",  32'(score_r),    32'd0);
    chk("held_in_play",   32'(ball_reset), 32'd0);
    score_right = 1'b0;
    cycle();
    chk("held_fall",      32'(score_r),    32'd0);
    score_right = 1'b1;
    cycle();
    chk("held_rise",      32'(score_r),    32'd1);
    chk("held_rise_dir",  32'(serve_dir),  32'd0);
    chk("held_rise_ball", 32'(ball_reset), 32'd1);
    score_right = 1'b0;
    cycle();

    // Right runs out the match.
    for (int p = 2; p <= 7; p++) begin
      serve_wait("rwin_serve");
      score_right = 1'b1;
      cycle();
      chk("rwin_score_r", 32'(score_r), 32'(p));
      score_right = 1'b0;
      cycle();
    end
    chk("rwin_over",    32'(game_over), 32'd1);
    chk("rwin_winner",  32'(winner),    32'd1);
    chk("rwin_score_l", 32'(score_l),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
